// File: rtl/ecc_host_link_if.sv
// ecc_host_link_if: host-side word streams of the ECC host link.
// s_* carries scalar words into the link, m_* carries result words back to the host.
interface ecc_host_link_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  // Host side: produces scalar words, consumes result words.
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  // Link side: consumes scalar words, produces result words.
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ecc_host_link.sv
// ecc_host_link: host-side front end for the 163-bit ECC point-multiplication top.
// Loads the scalar as six 32-bit words (LSW first), pulses ecc_enable, waits for a fresh
// rise of ecc_done, captures dx/dy and returns them as twelve words (dx LSW first, then dy).
// Build macro ECC_LINK_TIMEOUT_EN adds a WAIT watchdog driving the sticky err flag.
module ecc_host_link #(
  parameter int unsigned KEY_W  = 163,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NWORDS = 6
`ifdef ECC_LINK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1048576
`endif
) (
  input  logic              clk,
  input  logic              rst,
  ecc_host_link_if.slave    host,
  output logic [KEY_W-1:0]  ecc_din,
  output logic              ecc_enable,
  input  logic [KEY_W-1:0]  ecc_dx,
  input  logic [KEY_W-1:0]  ecc_dy,
  input  logic              ecc_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NBEATS = 2 * NWORDS;
  localparam int unsigned CNT_W  = $clog2(NBEATS);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   beat_nxt;
  logic               done_q;
  logic               done_rise;
  logic               timeout_hit;
  logic               load_beat;
  logic               send_beat;
  logic               send_enter;
  logic [KEY_W-1:0]   dx_q;
  logic [KEY_W-1:0]   dy_q;
  logic [KEY_W-1:0]   src_x;
  logic [KEY_W-1:0]   src_y;
  logic [KEY_W-1:0]   din_nxt;
  int unsigned        din_shift;
  logic [WORD_W-1:0]  word_nxt;
  logic               s_ready_q;
  logic               m_valid_q;
  logic [WORD_W-1:0]  m_data_q;
  logic               m_last_q;

  // Host word k of a KEY_W value; bits above KEY_W read as zero.
  function automatic logic [WORD_W-1:0] word_of(input logic [KEY_W-1:0] v, input int unsigned k);
    return WORD_W'(v >> (k * WORD_W));
  endfunction

  assign done_rise = ecc_done & ~done_q;

  assign host.s_ready = s_ready_q;
  assign host.m_valid = m_valid_q;
  assign host.m_data  = m_data_q;
  assign host.m_last  = m_last_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // Next-state logic and per-cycle handshake strobes.
  always_comb begin
    state_d   = state_q;
    load_beat = 1'b0;
    send_beat = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (host.s_valid && s_ready_q) begin
          load_beat = 1'b1;
          if (cnt_q == CNT_W'(NWORDS - 1)) state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise)        state_d = S_CAPTURE;
        else if (timeout_hit) state_d = S_SEND;
      end
      S_CAPTURE: state_d = S_SEND;
      S_SEND: begin
        if (m_valid_q && host.m_ready) begin
          send_beat = 1'b1;
          if (cnt_q == CNT_W'(NBEATS - 1)) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign send_enter = (state_q != S_SEND) && (state_d == S_SEND);

  // Scalar with the current host word merged in; bits shifted past KEY_W are dropped.
  always_comb begin
    din_shift = 32'(cnt_q) * WORD_W;
    din_nxt   = (ecc_din & ~(KEY_W'({WORD_W{1'b1}}) << din_shift))
              | (KEY_W'(host.s_data) << din_shift);
  end

  // Next result word: beat 0 on SEND entry, otherwise the beat after the current one.
  always_comb begin
    word_nxt = '0;
    src_x    = (state_q == S_CAPTURE) ? ecc_dx : dx_q;
    src_y    = (state_q == S_CAPTURE) ? ecc_dy : dy_q;
    beat_nxt = (state_q == S_SEND) ? cnt_q + CNT_W'(1) : '0;
    if (beat_nxt < CNT_W'(NWORDS)) word_nxt = word_of(src_x, 32'(beat_nxt));
    else                           word_nxt = word_of(src_y, 32'(beat_nxt - CNT_W'(NWORDS)));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ecc_din    <= '0;
      ecc_enable <= 1'b0;
      busy       <= 1'b0;
      s_ready_q  <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      done_q     <= ecc_done;
      ecc_enable <= (state_d == S_START);
      busy       <= (state_d != S_LOAD);
      s_ready_q  <= (state_d == S_LOAD);
      if (load_beat) begin
        ecc_din <= din_nxt;
        cnt_q   <= (state_d == S_START) ? '0 : cnt_q + CNT_W'(1);
      end
      if (state_q == S_CAPTURE) begin
        dx_q  <= ecc_dx;
        dy_q  <= ecc_dy;
        cnt_q <= '0;
      end
      if (send_enter) begin
        m_valid_q <= 1'b1;
        m_data_q  <= word_nxt;
        m_last_q  <= 1'b0;
      end else if (send_beat) begin
        if (state_d == S_LOAD) begin
          m_valid_q <= 1'b0;
          m_data_q  <= '0;
          m_last_q  <= 1'b0;
          cnt_q     <= '0;
        end else begin
          cnt_q     <= beat_nxt;
          m_data_q  <= word_nxt;
          m_last_q  <= (beat_nxt == CNT_W'(NBEATS - 1));
        end
      end
    end
  end

`ifdef ECC_LINK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign err         = err_q;

  // Watchdog: counts WAIT cycles from zero; an expiry latches err until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q != S_WAIT) wait_cnt_q <= '0;
      else                   wait_cnt_q <= wait_cnt_q + TO_W'(1);
      if (timeout_hit && !done_rise) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
